rr_stream_dispatcher: RTL and testbench
=======================================

# rr_stream_dispatcher

Single-input, multi-output valid/ready stream dispatcher. Each accepted input beat goes to the next output lane in strict round-robin order (0, 1, …, NUM_ELEM-1, 0, …). The beat passes through a single registered holding stage. Non-selected lanes carry zero data, matching the one-hot output convention of the codebase's `demux`. It sits where a worker pool is fed from one producer, upstream of per-lane consumers.

## Interface
Parameters:
- `NUM_ELEM`, 6, number of output lanes; must be ≥ 2, need not be a power of two.
- `ELEM_WIDTH`, 8, data width of each beat.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `arst_i`  in  1  asynchronous, active-high reset.
- `data_in_i`  in  ELEM_WIDTH  input beat data.
- `data_in_valid_i`  in  1  input beat valid.
- `data_in_ready_o`  out  1  dispatcher can accept a beat this cycle.
- `data_out_o`  out  NUM_ELEM×ELEM_WIDTH  packed per-lane data; non-selected lanes are all-zero.
- `data_out_valid_o`  out  NUM_ELEM  per-lane valid; at most one bit set.
- `data_out_ready_i`  in  NUM_ELEM  per-lane consumer ready.
- `sel_o`  out  $clog2(NUM_ELEM)  lane index the held beat targets; when empty, the lane the next accepted beat will target.

## Operation
- State:
  - `full` flag.
  - `hold_data` register, ELEM_WIDTH bits.
  - `hold_sel` register, lane index.
  - `ptr` round-robin pointer, lane index.
- Input handshake: a beat is accepted when `data_in_valid_i && data_in_ready_o`.
- Output handshake on lane i: `data_out_valid_o[i] && data_out_ready_i[i]`.
- `drain` = `full && data_out_ready_i[hold_sel]`.
- `data_in_ready_o` = `!full || drain`. The ready path is combinational from the selected lane's ready, so back-to-back beats flow at one per cycle.
- On accept:
  - `hold_data` ← `data_in_i`.
  - `hold_sel` ← `ptr`.
  - `ptr` ← `ptr + 1`, or 0 if `ptr == NUM_ELEM-1`.
- `full` next value:
  - 1 on accept (including accept and drain in the same cycle).
  - 0 on drain without accept.
  - otherwise unchanged.
- Outputs:
  - `data_out_valid_o[i]` = `full && hold_sel == i`.
  - `data_out_o[i]` = `hold_data` when `full && hold_sel == i`, else 0.
  - `sel_o` = `full ? hold_sel : ptr`.
- Strict round robin: the pointer never skips a lane. A stalled target lane stalls the whole dispatcher (head-of-line blocking is intended; order across lanes is preserved).
- Ready on non-selected lanes is ignored.
- Valid is not withdrawn once asserted: a held beat stays stable until its lane handshakes.
- Indices ≥ NUM_ELEM are never produced.

## Timing
- Reset values (asynchronous, immediate on `arst_i` high):
  - `full`=0, `ptr`=0, `hold_sel`=0, `hold_data`=0.
  - Hence `data_out_valid_o`=0, `data_out_o`=0, `sel_o`=0, `data_in_ready_o`=1.
- Latency: a beat accepted at edge N is valid on its lane in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle when each target lane is ready on its turn.
- Simultaneous drain and accept: the new beat replaces the old in the same edge, with no bubble.
- Wrap-around: after lane NUM_ELEM-1 the next beat targets lane 0, including for non-power-of-two NUM_ELEM.
- Reset mid-operation: any held beat is discarded (not delivered), and the pointer restarts at lane 0.
- `data_in_valid_i` may deassert at any time with no effect on a held beat.

## Test plan
All scenarios use NUM_ELEM=6, ELEM_WIDTH=8.
- Reset check: assert `arst_i` between edges → all valid=0, `data_out_o`=0, `sel_o`=0, `data_in_ready_o`=1 immediately.
- Streaming, all lanes ready: send beats 0x10..0x17 on consecutive cycles → lanes 0,1,2,3,4,5,0,1 receive 0x10..0x17, one beat per cycle, 1-cycle latency, other lanes zero.
- Stall: lane 2 ready=0 while beat 0x22 is held → `data_in_ready_o`=0, data stable, `sel_o`=2. Raise lane-2 ready for one cycle → handshake, and next beat 0x23 targets lane 3 in the same edge.
- Bubbles: input valid toggles 1,0,1,0 with beats 0xA0, 0xA1 → delivered to lanes 0 then 1; the pointer does not advance on idle cycles.
- Ignored ready: beat on lane 4, lanes 0–3 and 5 ready=1, lane 4 ready=0 → no handshake, beat held.
- Reset mid-operation: hold beat 0x55 on lane 3, pulse `arst_i` → valid drops at once, and the next beat 0x66 goes to lane 0.

Source files
------------

// File: rtl/rr_stream_dispatcher.sv
// rr_stream_dispatcher: one valid/ready producer fanned out to NUM_ELEM lanes
// in strict round-robin order through a single registered holding stage.
// Non-selected lanes present all-zero data (one-hot output convention).
module rr_stream_dispatcher #(
    parameter int NUM_ELEM   = 6,
    parameter int ELEM_WIDTH = 8,
    localparam int SEL_W     = $clog2(NUM_ELEM)
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic [ELEM_WIDTH-1:0]          data_in_i,
    input  logic                           data_in_valid_i,
    output logic                           data_in_ready_o,
    output logic [NUM_ELEM*ELEM_WIDTH-1:0] data_out_o,
    output logic [NUM_ELEM-1:0]            data_out_valid_o,
    input  logic [NUM_ELEM-1:0]            data_out_ready_i,
    output logic [SEL_W-1:0]               sel_o
);

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_ELEM - 1);

    logic                  full_q,      full_d;
    logic [ELEM_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [SEL_W-1:0]      hold_sel_q,  hold_sel_d;
    logic [SEL_W-1:0]      ptr_q,       ptr_d;

    logic drain;
    logic accept;

    // Only the targeted lane's ready matters; others are ignored. The ready
    // path is combinational so a draining beat can be replaced in the same edge.
    assign drain           = full_q && data_out_ready_i[hold_sel_q];
    assign data_in_ready_o = !full_q || drain;
    assign accept          = data_in_valid_i && data_in_ready_o;
    assign sel_o           = full_q ? hold_sel_q : ptr_q;

    // Next-state: capture on accept, advance pointer with explicit wrap so
    // non-power-of-two lane counts never produce an out-of-range index.
    always_comb begin
        full_d      = full_q;
        hold_data_d = hold_data_q;
        hold_sel_d  = hold_sel_q;
        ptr_d       = ptr_q;
        if (accept) begin
            full_d      = 1'b1;
            hold_data_d = data_in_i;
            hold_sel_d  = ptr_q;
            ptr_d       = (ptr_q == LAST_LANE) ? '0 : ptr_q + SEL_W'(1);
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat and restarts at lane 0.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            full_q      <= 1'b0;
            hold_data_q <= '0;
            hold_sel_q  <= '0;
            ptr_q       <= '0;
        end else begin
            full_q      <= full_d;
            hold_data_q <= hold_data_d;
            hold_sel_q  <= hold_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    // Per-lane one-hot valid and zero-masked data.
    generate
        for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_lane
            assign data_out_valid_o[gi] = full_q && (hold_sel_q == SEL_W'(gi));
            assign data_out_o[gi*ELEM_WIDTH +: ELEM_WIDTH] =
                data_out_valid_o[gi] ? hold_data_q : '0;
        end
    endgenerate

endmodule

// File: tb/tb_rr_stream_dispatcher.sv
// Self-checking bench for rr_stream_dispatcher (NUM_ELEM=6, ELEM_WIDTH=8).
// Accepted beats are pushed to a scoreboard with the lane they must reach;
// each cycle the head of the scoreboard defines the expected outputs.
module tb_rr_stream_dispatcher;

    localparam int N = 6;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           vin = 1'b0;
    logic           rdy_o;
    logic [N*W-1:0] dout;
    logic [N-1:0]   vout;
    logic [N-1:0]   rdy_i = '1;
    logic [2:0]     sel;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        int          lane;
        logic [W-1:0] data;
    } beat_t;

    beat_t sb[$];
    int    mptr = 0;

    rr_stream_dispatcher #(.NUM_ELEM(N), .ELEM_WIDTH(W)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .data_in_i        (din),
        .data_in_valid_i  (vin),
        .data_in_ready_o  (rdy_o),
        .data_out_o       (dout),
        .data_out_valid_o (vout),
        .data_out_ready_i (rdy_i),
        .sel_o            (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: sampled on the falling edge, predicts what the
    // next rising edge will do and updates the model accordingly.
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    logic [2:0]     es;
    bit             drn;
    bit             er;
    always @(negedge clk) begin
        if (!arst) begin
            ev = '0;
            ed = '0;
            es = 3'(mptr);
            drn = 1'b0;
            if (sb.size() > 0) begin
                ev[sb[0].lane] = 1'b1;
                ed[sb[0].lane*W +: W] = sb[0].data;
                es = 3'(sb[0].lane);
                drn = rdy_i[sb[0].lane];
            end
            er = (sb.size() == 0) || drn;
            check("valid", 64'(vout), 64'(ev));
            check("data",  64'(dout), 64'(ed));
            check("sel",   64'(sel),  64'(es));
            check("ready", 64'(rdy_o), 64'(er));
            if (drn) begin
                $display("deliver lane=%0d data=%02h", sb[0].lane, sb[0].data);
                void'(sb.pop_front());
            end
            if (vin && er) begin
                sb.push_back('{lane: mptr, data: din});
                $display("accept  data=%02h -> lane=%0d", din, mptr);
                mptr = (mptr == N-1) ? 0 : mptr + 1;
            end
        end
    end

    // One cycle of stimulus, driven just after the rising edge.
    task automatic cyc(input bit v, input logic [W-1:0] d, input logic [N-1:0] r);
        @(posedge clk);
        #1;
        vin   = v;
        din   = d;
        rdy_i = r;
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        arst = 1'b1;
        vin  = 1'b0;
        #1;
        check("rst_valid", 64'(vout), 64'd0);
        check("rst_data",  64'(dout), 64'd0);
        check("rst_sel",   64'(sel),  64'd0);
        check("rst_ready", 64'(rdy_o), 64'd1);
        sb.delete();
        mptr = 0;
        @(negedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #1;
        check("por_valid", 64'(vout), 64'd0);
        check("por_data",  64'(dout), 64'd0);
        check("por_sel",   64'(sel),  64'd0);
        check("por_ready", 64'(rdy_o), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        arst = 1'b0;

        do_reset();

        // Streaming, all lanes ready: 0x10..0x17 -> lanes 0..5,0,1
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), '1);
        cyc(1'b0, 8'h00, '1);
        cyc(1'b0, 8'h00, '1);

        // Stall on lane 2 with 0x22 held, 0x23 waiting at the input
        cyc(1'b1, 8'h22, 6'b111011);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h23, 6'b111011);
            @(negedge clk);
            check("stall_ready", 64'(rdy_o), 64'd0);
            check("stall_sel",   64'(sel),   64'd2);
            check("stall_data",  64'(dout[2*W +: W]), 64'h22);
        end
        cyc(1'b1, 8'h23, '1);   // drain 0x22 and accept 0x23 in the same edge
        cyc(1'b0, 8'h00, 6'b110111);
        @(negedge clk);
        check("swap_valid", 64'(vout), 64'b001000);
        check("swap_data",  64'(dout[3*W +: W]), 64'h23);
        cyc(1'b0, 8'h00, '1);
        cyc(1'b0, 8'h00, '1);

        // Ignored ready: beat on lane 4, every other lane ready
        cyc(1'b1, 8'hB4, 6'b101111);
        cyc(1'b0, 8'h00, 6'b101111);
        cyc(1'b0, 8'h00, 6'b101111);
        @(negedge clk);
        check("ign_valid", 64'(vout), 64'b010000);
        check("ign_data",  64'(dout[4*W +: W]), 64'hB4);
        cyc(1'b0, 8'h00, '1);

        // Filler to lane 5, then bubbles 0xA0/0xA1 to lanes 0/1
        cyc(1'b1, 8'hC5, '1);
        cyc(1'b1, 8'hA0, '1);
        cyc(1'b0, 8'h00, '1);
        cyc(1'b1, 8'hA1, '1);
        cyc(1'b0, 8'h00, '1);
        cyc(1'b0, 8'h00, '1);

        // Reset mid-operation: 0x55 held on lane 3 is discarded
        cyc(1'b1, 8'hD2, '1);
        cyc(1'b1, 8'h55, 6'b110111);
        cyc(1'b0, 8'h00, 6'b110111);
        @(negedge clk);
        check("hold55_valid", 64'(vout), 64'b001000);
        do_reset();
        cyc(1'b1, 8'h66, 6'b111110);
        cyc(1'b0, 8'h00, 6'b111110);
        @(negedge clk);
        check("post_rst_valid", 64'(vout), 64'b000001);
        check("post_rst_data",  64'(dout[W-1:0]), 64'h66);
        cyc(1'b0, 8'h00, '1);
        cyc(1'b0, 8'h00, '1);
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
